// File: rtl/toggle_event_rx.sv
// Destination-domain receiver for a toggle-encoded event line: synchronizes the
// toggle, turns each level change into a pulse and buffers events as a valid/ready stream.
module toggle_event_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic             toggle_i,
  output logic             pulse_o,
  output logic             event_valid_o,
  input  logic             event_ready_i,
  output logic [CNT_W-1:0] pending_o,
  output logic             overflow_o,
  input  logic             overflow_clr_i,
  output logic             init_done_o
);

  localparam int unsigned INIT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [INIT_W-1:0]      init_cnt;

  logic                   sync_last;
  logic                   tog_edge;
  logic                   inc;
  logic                   dec;
  logic                   ovf_set;
  logic [CNT_W-1:0]       cnt_nxt;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign tog_edge  = sync_last ^ hist_q;

  // Synchronizer chain and edge-detect history run in every state.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
      hist_q <= sync_last;
    end
  end

  // INIT absorbs edges while the chain fills with valid samples.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      init_done_o <= 1'b0;
      pulse_o     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          pulse_o <= 1'b0;
          if (init_cnt == INIT_LAST) begin
            state       <= ST_RUN;
            init_done_o <= 1'b1;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end
        ST_RUN: begin
          pulse_o <= tog_edge;
        end
        default: begin
          state   <= ST_INIT;
          pulse_o <= 1'b0;
        end
      endcase
    end
  end

  // Saturating pending-count update; a simultaneous accept cancels an arrival.
  always_comb begin
    inc     = pulse_o;
    dec     = event_valid_o & event_ready_i;
    cnt_nxt = pending_o;
    ovf_set = 1'b0;
    if (inc && !dec) begin
      if (pending_o == CNT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        cnt_nxt = pending_o + CNT_W'(1);
      end
    end else if (!inc && dec) begin
      cnt_nxt = pending_o - CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      pending_o     <= '0;
      event_valid_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      pending_o     <= cnt_nxt;
      event_valid_o <= (cnt_nxt != '0);
      if (ovf_set) begin
        overflow_o <= 1'b1;
      end else if (overflow_clr_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Self-checking bench for toggle_event_rx: directed and random stimulus against an
// edge-indexed reference model of the toggle samples and the pending-event count.
module tb_toggle_event_rx;

  localparam int unsigned S    = 2;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          aclk = 1'b0;
  logic          arstn;
  logic          toggle_i;
  logic          pulse_o;
  logic          event_valid_o;
  logic          event_ready_i;
  logic [CW-1:0] pending_o;
  logic          overflow_o;
  logic          overflow_clr_i;
  logic          init_done_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state: toggle value sampled at each edge since reset release.
  logic samp[$];
  int   e;
  logic m_pulse;
  int   m_cnt;
  logic m_ovf;
  logic m_done;
  logic tog;

  toggle_event_rx #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .toggle_i      (toggle_i),
    .pulse_o       (pulse_o),
    .event_valid_o (event_valid_o),
    .event_ready_i (event_ready_i),
    .pending_o     (pending_o),
    .overflow_o    (overflow_o),
    .overflow_clr_i(overflow_clr_i),
    .init_done_o   (init_done_o)
  );

  always #5 aclk = ~aclk;

  function automatic logic s(input int i);
    if (i < 0) return 1'b0;
    return samp[i];
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic t, input logic r, input logic c, input logic rn);
    logic inc, dec, drop;
    if (!rn) begin
      samp.delete();
      e       = 0;
      m_pulse = 1'b0;
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_done  = 1'b0;
    end else begin
      inc  = m_pulse;
      dec  = (m_cnt > 0) && r;
      drop = inc && !dec && (m_cnt == MAXC);
      if (inc && !dec && !drop) m_cnt++;
      else if (!inc && dec) m_cnt--;
      if (drop) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      samp.push_back(t);
      m_pulse = (e >= int'(S) + 1) && (s(e - int'(S)) != s(e - int'(S) - 1));
      m_done  = (e >= int'(S));
      e++;
    end
  endtask

  task automatic cyc(input logic t, input logic r, input logic c, input logic rn);
    toggle_i       = t;
    event_ready_i  = r;
    overflow_clr_i = c;
    arstn          = rn;
    @(posedge aclk);
    model_edge(t, r, c, rn);
    #1;
    chk("pulse",    int'(pulse_o),       int'(m_pulse));
    chk("valid",    int'(event_valid_o), int'(m_cnt > 0));
    chk("pending",  int'(pending_o),     m_cnt);
    chk("overflow", int'(overflow_o),    int'(m_ovf));
    chk("init",     int'(init_done_o),   int'(m_done));
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) cyc(tog, r, 1'b0, 1'b1);
  endtask

  task automatic toggles(input int n, input int spacing, input logic r);
    repeat (n) begin
      tog = ~tog;
      idle(spacing, r);
    end
  endtask

  // Toggle, then raise ready exactly in the cycle the pulse is visible.
  task automatic toggle_accept_on_pulse(input logic c);
    tog = ~tog;
    idle(int'(S) + 1, 1'b0);
    cyc(tog, 1'b1, c, 1'b1);
    idle(3, 1'b0);
  endtask

  initial begin
    tog = 1'b1;
    // Reset with the toggle held high: priming must absorb the initial level.
    repeat (3) cyc(tog, 1'b0, 1'b0, 1'b0);
    idle(8, 1'b1);
    chk("init_after_prime", int'(init_done_o), 1);

    // Single event with the consumer always ready.
    toggles(1, 8, 1'b1);

    // Five buffered events, then drain.
    toggles(5, 4, 1'b0);
    chk("pending_five", int'(pending_o), 5);
    idle(8, 1'b1);

    // Saturation and overflow, then clear.
    toggles(17, 4, 1'b0);
    chk("pending_sat", int'(pending_o), MAXC);
    chk("overflow_set", int'(overflow_o), 1);
    cyc(tog, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);
    chk("overflow_clr", int'(overflow_o), 0);

    // Simultaneous arrival and accept at full: no change, no overflow.
    toggle_accept_on_pulse(1'b0);
    chk("full_incdec", int'(pending_o), MAXC);
    chk("full_incdec_ovf", int'(overflow_o), 0);

    // Drop coinciding with a clear: set wins.
    toggle_accept_on_pulse(1'b0);
    tog = ~tog;
    idle(int'(S) + 1, 1'b0);
    cyc(tog, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);
    chk("set_wins", int'(overflow_o), 1);

    // Drain to three, then simultaneous inc and dec at three.
    cyc(tog, 1'b0, 1'b1, 1'b1);
    idle(MAXC - 3, 1'b1);
    idle(2, 1'b0);
    chk("pending_three", int'(pending_o), 3);
    toggle_accept_on_pulse(1'b0);
    chk("mid_incdec", int'(pending_o), 3);
    idle(6, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) tog = ~tog;
      cyc(tog, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 1'b1);
    end
    idle(10, 1'b1);

    // Reset mid-operation with seven pending and a toggle in flight.
    toggles(7, 4, 1'b0);
    chk("pending_seven", int'(pending_o), 7);
    tog = ~tog;
    cyc(tog, 1'b0, 1'b0, 1'b1);
    cyc(tog, 1'b0, 1'b0, 1'b0);
    chk("rst_pending", int'(pending_o), 0);
    chk("rst_init", int'(init_done_o), 0);
    idle(10, 1'b0);
    toggles(3, 4, 1'b1);

    // Short random burst including resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) tog = ~tog;
      cyc(tog, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 63) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
